sensor_input_conditioner: RTL and testbench
===========================================

// Module: sensor_input_conditioner
// PURPOSE
//   Upstream front end of the irrigation controller. Synchronises and debounces the raw
//   field sensors: tank level h/m/l, soil humidity us, air humidity ua and temperature t.
//   Checks that the tank-level combination is physically valid and presents clean,
//   registered sensor bits to the tank/alarm, irrigation-type and M7 display logic.
// PARAMETERS
//   DB_CYCLES    16  consecutive differing samples required before a filtered bit changes (>=2)
//   CNT_W        5   width of debounce counters; must hold DB_CYCLES-1
//   FAULT_CYCLES 8   consecutive invalid/valid level samples needed to enter/leave FAULT (>=2)
// PORTS
//   clk       in   1  system clock, all logic on rising edge
//   rst_n     in   1  synchronous active-low reset
//   h_raw     in   1  raw tank-high sensor, asynchronous
//   m_raw     in   1  raw tank-medium sensor, asynchronous
//   l_raw     in   1  raw tank-low sensor, asynchronous
//   us_raw    in   1  raw soil-humidity sensor (1 = soil wet), asynchronous
//   ua_raw    in   1  raw air-humidity sensor (1 = air humid), asynchronous
//   t_raw     in   1  raw temperature sensor (1 = hot), asynchronous
//   h, m, l   out  1  validated tank level bits (registered)
//   us,ua,t   out  1  debounced humidity/temperature bits (registered)
//   lvl_fault out  1  level sensors in persistent invalid combination
//   upd       out  1  1-cycle pulse, coincident with any change on h,m,l,us,ua,t
// BEHAVIOUR
//   Reset (rst_n=0 at edge): h=m=l=0, us=1, ua=1, t=0, lvl_fault=0, upd=0; sync flops,
//     debounce counters, level FSM (->OK) and fault counter all cleared. Same mid-operation.
//   Sync: each raw input passes through a 2-flop synchroniser (s1->s2).
//   Debounce per bit x (internal flt_x, reset as outputs): each edge
//     s2==flt_x -> cnt_x<=0; else cnt_x==DB_CYCLES-1 -> flt_x<=s2, cnt_x<=0; else cnt_x++.
//     Any agreeing sample restarts the count; bits are independent, simultaneous changes OK.
//   Output stage: one register after flt; us/ua/t copy flt; h/m/l come from level stage.
//   Latency: stable raw change -> output change after 2+DB_CYCLES+1 edges (19 at defaults).
//   Level validity on {flt_h,flt_m,flt_l}: valid = 000,001,011,111; all others invalid.
//   Level FSM (fcnt, width to hold FAULT_CYCLES-1):
//     OK:      valid -> {h,m,l}<=flt; invalid -> SUSPECT, fcnt<=1, outputs hold.
//     SUSPECT: valid -> OK, {h,m,l}<=flt; invalid & fcnt==FAULT_CYCLES-1 -> FAULT, fcnt<=0;
//              else fcnt++. Outputs hold last valid level.
//     FAULT:   lvl_fault=1; outputs hold last valid level; invalid -> fcnt<=0;
//              valid & fcnt==FAULT_CYCLES-1 -> OK, {h,m,l}<=flt, fcnt<=0; else fcnt++.
//   lvl_fault registered: 1 exactly while state==FAULT.
//   upd: registered, high in the cycle where any of h,m,l,us,ua,t differs from previous
//     value; never high in the cycle after reset release unless an output changed.
//   No counter wraps: debounce counters saturate by clearing at DB_CYCLES-1.
// TESTING
//   T1 reset: rst_n=0 2 cycles, raw all 1 -> h,m,l=000, us=1,ua=1,t=0, lvl_fault=0, upd=0.
//   T2 l_raw 0->1 held -> l rises exactly 19 edges later, upd=1 for that one cycle only.
//   T3 t_raw pulse 15 cycles wide -> t stays 0, no upd; 16 cycles wide -> t=1 at edge 19.
//   T4 level 011 then h_raw=1,m_raw=0 (101) held -> h,m,l stay 011; lvl_fault=1 after
//      FAULT_CYCLES invalid samples; restore 111 -> lvl_fault=0 after 8 valid, h,m,l=111.
//   T5 invalid 101 for 5 filtered cycles then 001 -> no lvl_fault, h,m,l=001.
//   T6 us_raw and ua_raw change same cycle, rst_n=0 at count 10 -> no output change, all defaults.

Source files
------------

// File: rtl/sensor_input_conditioner.sv
// sensor_input_conditioner
// Front end of the irrigation controller: synchronises and debounces the raw
// tank-level, humidity and temperature sensors, screens the tank-level
// combination for physical validity and drives clean registered sensor bits.
module sensor_input_conditioner #(
    parameter int DB_CYCLES    = 16,
    parameter int CNT_W        = 5,
    parameter int FAULT_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic h_raw,
    input  logic m_raw,
    input  logic l_raw,
    input  logic us_raw,
    input  logic ua_raw,
    input  logic t_raw,
    output logic h,
    output logic m,
    output logic l,
    output logic us,
    output logic ua,
    output logic t,
    output logic lvl_fault,
    output logic upd
);

    // Bit order used for every 6-bit sensor vector: {h, m, l, us, ua, t}
    localparam int NB = 6;
    localparam int FC_W = (FAULT_CYCLES > 2) ? $clog2(FAULT_CYCLES) : 1;

    // Idle value of the sensor bits: tank empty, soil wet, air humid, not hot
    localparam logic [NB-1:0]    RST_VAL = 6'b000110;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FAULT_CYCLES - 1);
    localparam logic [FC_W-1:0]  FC_ONE  = FC_W'(1);

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULT   = 2'd2
    } lvl_state_t;

    logic [NB-1:0]    w_raw;
    logic [NB-1:0]    r_s1;
    logic [NB-1:0]    r_s2;
    logic [NB-1:0]    r_flt;
    logic [CNT_W-1:0] r_cnt [NB];

    lvl_state_t       r_state;
    lvl_state_t       w_state_nxt;
    logic [FC_W-1:0]  r_fcnt;
    logic [FC_W-1:0]  w_fcnt_nxt;
    logic [2:0]       w_lvl;
    logic             w_lvl_valid;
    logic             w_lvl_load;

    logic [NB-1:0]    w_out_nxt;
    logic [NB-1:0]    r_out;
    logic             r_fault;
    logic             r_upd;

    assign w_raw = {h_raw, m_raw, l_raw, us_raw, ua_raw, t_raw};

    // Two-flop synchroniser on every asynchronous sensor input
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    // Per-bit debounce: a filtered bit only follows after DB_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flt <= RST_VAL;
            for (int i = 0; i < NB; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (r_s2[i] == r_flt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_LAST) begin
                    r_flt[i] <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Only "filled from the bottom" tank readings are physically possible
    assign w_lvl       = r_flt[5:3];
    assign w_lvl_valid = (w_lvl == 3'b000) || (w_lvl == 3'b001) ||
                         (w_lvl == 3'b011) || (w_lvl == 3'b111);

    // Level FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_OK;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    // Level FSM next state: suspect on a bad reading, fault only when the bad
    // reading persists, and leave fault only after a persistent good reading
    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        w_lvl_load  = 1'b0;
        case (r_state)
            ST_OK: begin
                if (w_lvl_valid) begin
                    w_lvl_load = 1'b1;
                end else begin
                    w_state_nxt = ST_SUSPECT;
                    w_fcnt_nxt  = FC_ONE;
                end
            end
            ST_SUSPECT: begin
                if (w_lvl_valid) begin
                    w_state_nxt = ST_OK;
                    w_lvl_load  = 1'b1;
                    w_fcnt_nxt  = '0;
                end else if (r_fcnt == FC_LAST) begin
                    w_state_nxt = ST_FAULT;
                    w_fcnt_nxt  = '0;
                end else begin
                    w_fcnt_nxt = r_fcnt + FC_ONE;
                end
            end
            ST_FAULT: begin
                if (!w_lvl_valid) begin
                    w_fcnt_nxt = '0;
                end else if (r_fcnt == FC_LAST) begin
                    w_state_nxt = ST_OK;
                    w_lvl_load  = 1'b1;
                    w_fcnt_nxt  = '0;
                end else begin
                    w_fcnt_nxt = r_fcnt + FC_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_OK;
                w_fcnt_nxt  = '0;
            end
        endcase
    end

    // Level bits hold the last accepted valid reading; the others track the filter
    assign w_out_nxt = {(w_lvl_load ? w_lvl : r_out[5:3]), r_flt[2:0]};

    // Output register, fault flag aligned with FAULT state, change pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out   <= RST_VAL;
            r_fault <= 1'b0;
            r_upd   <= 1'b0;
        end else begin
            r_out   <= w_out_nxt;
            r_fault <= (w_state_nxt == ST_FAULT);
            r_upd   <= (w_out_nxt != r_out);
        end
    end

    assign {h, m, l, us, ua, t} = r_out;
    assign lvl_fault            = r_fault;
    assign upd                  = r_upd;

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Testbench for sensor_input_conditioner: directed scenarios followed by a
// randomized phase, all compared every cycle against a window-based model.
module tb_sensor_input_conditioner;

    localparam int DB_CYCLES    = 16;
    localparam int CNT_W        = 5;
    localparam int FAULT_CYCLES = 8;
    localparam logic [31:0] DB_MASK = (32'h1 << DB_CYCLES) - 32'h1;
    localparam logic [5:0]  DEF_OUT = 6'b000110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic h_raw = 1'b0, m_raw = 1'b0, l_raw = 1'b0;
    logic us_raw = 1'b1, ua_raw = 1'b1, t_raw = 1'b0;
    logic h, m, l, us, ua, t, lvl_fault, upd;

    sensor_input_conditioner #(
        .DB_CYCLES   (DB_CYCLES),
        .CNT_W       (CNT_W),
        .FAULT_CYCLES(FAULT_CYCLES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .h_raw    (h_raw),
        .m_raw    (m_raw),
        .l_raw    (l_raw),
        .us_raw   (us_raw),
        .ua_raw   (ua_raw),
        .t_raw    (t_raw),
        .h        (h),
        .m        (m),
        .l        (l),
        .us       (us),
        .ua       (ua),
        .t        (t),
        .lvl_fault(lvl_fault),
        .upd      (upd)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    string phase    = "INIT";

    // Reference model state, vector order {h, m, l, us, ua, t}
    logic [5:0]  m_s1, m_s2, m_flt, m_out;
    logic        m_fault, m_upd;
    logic [31:0] m_hist [6];
    int          m_since [6];
    int          m_inv_run, m_val_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    endtask

    // One clock edge of the behavioural model. Filtered bits flip once the last
    // DB_CYCLES synchronised samples since the previous flip all disagree; the
    // level bits follow valid readings, latch on persistent invalid readings.
    task automatic model_edge(input logic rs, input logic [5:0] rw);
        logic [5:0]  prev;
        logic [2:0]  lvl;
        logic        ok;
        logic [31:0] want;
        if (!rs) begin
            m_s1 = '0; m_s2 = '0;
            m_flt = DEF_OUT; m_out = DEF_OUT;
            m_fault = 1'b0; m_upd = 1'b0;
            m_inv_run = 0; m_val_run = 0;
            for (int i = 0; i < 6; i++) begin
                m_hist[i] = '0; m_since[i] = 0;
            end
        end else begin
            prev = m_out;
            lvl  = m_flt[5:3];
            ok   = (lvl == 3'b000) || (lvl == 3'b001) || (lvl == 3'b011) || (lvl == 3'b111);
            if (ok) begin m_val_run++; m_inv_run = 0; end
            else begin m_inv_run++; m_val_run = 0; end
            if (!m_fault) begin
                if (ok) m_out[5:3] = lvl;
                else if (m_inv_run >= FAULT_CYCLES) m_fault = 1'b1;
            end else if (m_val_run >= FAULT_CYCLES) begin
                m_fault = 1'b0;
                m_out[5:3] = lvl;
            end
            m_out[2:0] = m_flt[2:0];
            m_upd = (m_out != prev);
            for (int i = 0; i < 6; i++) begin
                m_hist[i] = {m_hist[i][30:0], m_s2[i]};
                m_since[i]++;
                want = m_flt[i] ? 32'h0 : DB_MASK;
                if (m_since[i] >= DB_CYCLES && (m_hist[i] & DB_MASK) == want) begin
                    m_flt[i] = ~m_flt[i];
                    m_since[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = rw;
        end
    endtask

    task automatic set_raw(input logic [5:0] v);
        {h_raw, m_raw, l_raw, us_raw, ua_raw, t_raw} = v;
    endtask

    task automatic step();
        logic [5:0] rw;
        logic       rs;
        rw = {h_raw, m_raw, l_raw, us_raw, ua_raw, t_raw};
        rs = rst_n;
        @(posedge clk);
        #1;
        model_edge(rs, rw);
        cyc++;
        chk({phase, "_out"},   32'({h, m, l, us, ua, t}), 32'(m_out));
        chk({phase, "_fault"}, 32'(lvl_fault),            32'(m_fault));
        chk({phase, "_upd"},   32'(upd),                  32'(m_upd));
    endtask

    initial begin
        int         first;
        int         n_upd;
        logic       seen;
        logic [2:0] hml_at;
        logic [5:0] v;
        int         hold;

        // T1: reset with all raw inputs high
        phase = "T1";
        rst_n = 1'b0;
        set_raw(6'b111111);
        step();
        step();
        chk("T1_outs",  32'({h, m, l, us, ua, t}), 32'(DEF_OUT));
        chk("T1_fault", 32'(lvl_fault), 32'h0);
        chk("T1_upd",   32'(upd), 32'h0);
        set_raw(DEF_OUT);
        rst_n = 1'b1;
        phase = "T1_rel";
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (upd !== 1'b0) seen = 1'b1;
        end
        chk("T1_no_upd_after_release", 32'(seen), 32'h0);

        // T2: l_raw rises and stays; l follows 19 edges later with one upd pulse
        phase = "T2";
        l_raw = 1'b1;
        first = -1;
        n_upd = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (first < 0 && l === 1'b1) first = k;
            if (upd === 1'b1) n_upd++;
        end
        chk("T2_l_latency", 32'(first), 32'd19);
        chk("T2_upd_pulses", 32'(n_upd), 32'd1);

        // T3: a 15-cycle pulse is rejected, a 16-cycle pulse passes
        phase = "T3a";
        t_raw = 1'b1;
        seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 16) t_raw = 1'b0;
            step();
            if (t !== 1'b0 || upd !== 1'b0) seen = 1'b1;
        end
        chk("T3_short_pulse_ignored", 32'(seen), 32'h0);
        phase = "T3b";
        t_raw = 1'b1;
        first = -1;
        for (int k = 1; k <= 45; k++) begin
            if (k == 17) t_raw = 1'b0;
            step();
            if (first < 0 && t === 1'b1) first = k;
        end
        chk("T3_long_pulse_latency", 32'(first), 32'd19);
        chk("T3_t_back_low", 32'(t), 32'h0);

        // T4: level 011, then invalid 101 until fault, then 111 until recovery
        phase = "T4a";
        m_raw = 1'b1;
        for (int k = 0; k < 25; k++) step();
        chk("T4_level_011", 32'({h, m, l}), 32'(3'b011));
        phase = "T4b";
        h_raw = 1'b1;
        m_raw = 1'b0;
        first = -1;
        seen  = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (first < 0 && lvl_fault === 1'b1) first = k;
            if ({h, m, l} !== 3'b011) seen = 1'b1;
        end
        chk("T4_fault_entry_edge", 32'(first), 32'd26);
        chk("T4_level_held", 32'(seen), 32'h0);
        phase = "T4c";
        m_raw = 1'b1;
        first  = -1;
        hml_at = 3'b000;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (first < 0 && lvl_fault === 1'b0) begin
                first  = k;
                hml_at = {h, m, l};
            end
        end
        chk("T4_fault_exit_edge", 32'(first), 32'd26);
        chk("T4_level_after_exit", 32'(hml_at), 32'(3'b111));

        // T5: invalid 101 for 5 filtered cycles, then 001
        phase = "T5";
        m_raw = 1'b0;
        seen  = 1'b0;
        hml_at = 3'b000;
        for (int k = 1; k <= 45; k++) begin
            if (k == 6) h_raw = 1'b0;
            step();
            if (lvl_fault !== 1'b0) seen = 1'b1;
            if (k == 22) hml_at = {h, m, l};
        end
        chk("T5_no_fault", 32'(seen), 32'h0);
        chk("T5_held_during_invalid", 32'(hml_at), 32'(3'b111));
        chk("T5_final_level", 32'({h, m, l}), 32'(3'b001));

        // T6: us/ua change together, reset lands mid-count
        phase = "T6";
        us_raw = 1'b0;
        ua_raw = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (upd !== 1'b0 || us !== 1'b1 || ua !== 1'b1) seen = 1'b1;
        end
        rst_n = 1'b0;
        set_raw(DEF_OUT);
        step();
        step();
        chk("T6_no_change_before_reset", 32'(seen), 32'h0);
        chk("T6_defaults", 32'({h, m, l, us, ua, t, lvl_fault, upd}), 32'({DEF_OUT, 2'b00}));
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (upd !== 1'b0 || {h, m, l, us, ua, t} !== DEF_OUT) seen = 1'b1;
        end
        chk("T6_quiet_after_reset", 32'(seen), 32'h0);

        // Randomized phase: held patterns of varying length, occasional reset
        phase = "RND";
        for (int s = 0; s < 180; s++) begin
            v    = 6'($urandom);
            hold = $urandom_range(1, 40);
            if ($urandom_range(0, 3) != 0)
                v = {h_raw, m_raw, l_raw, us_raw, ua_raw, t_raw} ^ (6'b000001 << $urandom_range(0, 5));
            set_raw(v);
            if ($urandom_range(0, 39) == 0) rst_n = 1'b0;
            for (int k = 0; k < hold; k++) begin
                step();
                if (k == 1) rst_n = 1'b1;
            end
            rst_n = 1'b1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
